control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: a step counter T0..T9 plus a halt mode, decoding
// one-hot bus control strobes from the current step, the opcode and a latched branch condition.
module control_sequencer #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 RUN,
  input  logic [BUS_WIDTH-1:0] INSTRUCTION,
  input  logic                 FLAG_C,
  input  logic                 FLAG_Z,
  output logic                 PC_ENABLE,
  output logic                 PC_COUNT,
  output logic                 PC_LOAD,
  output logic                 MAR_LOAD,
  output logic                 RAM_ENABLE,
  output logic                 RAM_LOAD,
  output logic                 IR_LOAD,
  output logic                 IR_ENABLE,
  output logic                 A_ENABLE,
  output logic                 A_LOAD,
  output logic                 B_LOAD,
  output logic                 ALU_ENABLE,
  output logic                 ALU_SUB,
  output logic                 FLAGS_LOAD,
  output logic                 OUT_LOAD,
  output logic [3:0]           STEP,
  output logic                 HALTED
);

  typedef enum logic {MODE_RUN, MODE_HALT} mode_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [3:0] opcode;
  logic       unused_operand;
  logic       fetch_only;
  logic       active;

  mode_t      mode_q, mode_d;
  logic [3:0] step_q, step_d;
  logic       cond_q, cond_d;
  logic       last_step, halt_req;

  logic pc_enable, pc_count, pc_load, mar_load, ram_enable, ram_load, ir_load;
  logic ir_enable, a_enable, a_load, b_load, alu_enable, alu_sub, flags_load, out_load;

  assign opcode         = INSTRUCTION[BUS_WIDTH-1 -: 4];
  assign unused_operand = ^INSTRUCTION[BUS_WIDTH-5:0];
  assign fetch_only     = (opcode == OP_NOP) || ((opcode >= 4'h9) && (opcode <= 4'hD));
  assign active         = RESET && RUN && (mode_q == MODE_RUN);

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      mode_q <= MODE_RUN;
      step_q <= 4'd0;
      cond_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
      cond_q <= cond_d;
    end
  end

  // Microcode decode and step sequencing; every opcode's last step wraps to T0.
  always_comb begin
    pc_enable  = 1'b0;
    pc_count   = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    ram_enable = 1'b0;
    ram_load   = 1'b0;
    ir_load    = 1'b0;
    ir_enable  = 1'b0;
    a_enable   = 1'b0;
    a_load     = 1'b0;
    b_load     = 1'b0;
    alu_enable = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    last_step  = 1'b0;
    halt_req   = 1'b0;
    mode_d     = mode_q;
    step_d     = step_q;
    cond_d     = cond_q;

    case (step_q)
      4'd0: pc_enable = 1'b1;
      4'd1: mar_load = 1'b1;
      4'd2: ram_enable = 1'b1;
      4'd3: begin
        ir_load   = 1'b1;
        pc_count  = 1'b1;
        last_step = fetch_only;
      end
      default: begin
        case (opcode)
          OP_LDA: begin
            case (step_q)
              4'd4: ir_enable = 1'b1;
              4'd5: mar_load = 1'b1;
              4'd6: ram_enable = 1'b1;
              4'd7: begin a_load = 1'b1; last_step = 1'b1; end
              default: last_step = 1'b1;
            endcase
          end
          OP_ADD, OP_SUB: begin
            case (step_q)
              4'd4: ir_enable = 1'b1;
              4'd5: mar_load = 1'b1;
              4'd6: ram_enable = 1'b1;
              4'd7: b_load = 1'b1;
              4'd8: begin
                alu_enable = 1'b1;
                alu_sub    = (opcode == OP_SUB);
              end
              4'd9: begin
                a_load     = 1'b1;
                flags_load = 1'b1;
                alu_sub    = (opcode == OP_SUB);
                last_step  = 1'b1;
              end
              default: last_step = 1'b1;
            endcase
          end
          OP_STA: begin
            case (step_q)
              4'd4: ir_enable = 1'b1;
              4'd5: begin mar_load = 1'b1; a_enable = 1'b1; end
              4'd6: begin ram_load = 1'b1; last_step = 1'b1; end
              default: last_step = 1'b1;
            endcase
          end
          OP_LDI: begin
            case (step_q)
              4'd4: ir_enable = 1'b1;
              4'd5: begin a_load = 1'b1; last_step = 1'b1; end
              default: last_step = 1'b1;
            endcase
          end
          OP_JMP: begin
            case (step_q)
              4'd4: ir_enable = 1'b1;
              4'd5: begin pc_load = 1'b1; last_step = 1'b1; end
              default: last_step = 1'b1;
            endcase
          end
          OP_JC, OP_JZ: begin
            case (step_q)
              4'd4: ir_enable = 1'b1;
              4'd5: begin pc_load = cond_q; last_step = 1'b1; end
              default: last_step = 1'b1;
            endcase
          end
          OP_OUT: begin
            case (step_q)
              4'd4: a_enable = 1'b1;
              4'd5: begin out_load = 1'b1; last_step = 1'b1; end
              default: last_step = 1'b1;
            endcase
          end
          OP_HLT: begin
            if (step_q == 4'd4) halt_req = 1'b1;
            else last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
    endcase

    // The branch condition is captured on the T4 edge, once the opcode is valid.
    if (RUN && (mode_q == MODE_RUN)) begin
      if (step_q == 4'd4) cond_d = (opcode == OP_JZ) ? FLAG_Z : FLAG_C;
      if (halt_req) begin
        mode_d = MODE_HALT;
        step_d = 4'd0;
      end else if (last_step) begin
        step_d = 4'd0;
      end else begin
        step_d = step_q + 4'd1;
      end
    end
  end

  assign PC_ENABLE  = active & pc_enable;
  assign PC_COUNT   = active & pc_count;
  assign PC_LOAD    = active & pc_load;
  assign MAR_LOAD   = active & mar_load;
  assign RAM_ENABLE = active & ram_enable;
  assign RAM_LOAD   = active & ram_load;
  assign IR_LOAD    = active & ir_load;
  assign IR_ENABLE  = active & ir_enable;
  assign A_ENABLE   = active & a_enable;
  assign A_LOAD     = active & a_load;
  assign B_LOAD     = active & b_load;
  assign ALU_ENABLE = active & alu_enable;
  assign ALU_SUB    = active & alu_sub;
  assign FLAGS_LOAD = active & flags_load;
  assign OUT_LOAD   = active & out_load;
  assign STEP       = step_q;
  assign HALTED     = (mode_q == MODE_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, hand-written corner sequences and
// randomized instruction streams checked against a microprogram-list reference model.
module tb_control_sequencer;

  localparam logic [14:0] K_PC_EN    = 15'h4000;
  localparam logic [14:0] K_PC_CNT   = 15'h2000;
  localparam logic [14:0] K_PC_LD    = 15'h1000;
  localparam logic [14:0] K_MAR_LD   = 15'h0800;
  localparam logic [14:0] K_RAM_EN   = 15'h0400;
  localparam logic [14:0] K_RAM_LD   = 15'h0200;
  localparam logic [14:0] K_IR_LD    = 15'h0100;
  localparam logic [14:0] K_IR_EN    = 15'h0080;
  localparam logic [14:0] K_A_EN     = 15'h0040;
  localparam logic [14:0] K_A_LD     = 15'h0020;
  localparam logic [14:0] K_B_LD     = 15'h0010;
  localparam logic [14:0] K_ALU_EN   = 15'h0008;
  localparam logic [14:0] K_ALU_SUB  = 15'h0004;
  localparam logic [14:0] K_FLAGS_LD = 15'h0002;
  localparam logic [14:0] K_OUT_LD   = 15'h0001;
  localparam logic [14:0] EN_MASK = K_PC_EN | K_RAM_EN | K_IR_EN | K_A_EN | K_ALU_EN;
  localparam logic [14:0] LD_MASK = K_PC_LD | K_MAR_LD | K_RAM_LD | K_IR_LD | K_A_LD |
                                    K_B_LD | K_FLAGS_LD | K_OUT_LD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b1;
  logic [15:0] instruction = 16'h0000;
  logic        flag_c = 1'b0;
  logic        flag_z = 1'b0;
  logic        pc_enable, pc_count, pc_load, mar_load, ram_enable, ram_load, ir_load;
  logic        ir_enable, a_enable, a_load, b_load, alu_enable, alu_sub, flags_load, out_load;
  logic [3:0]  step;
  logic        halted;
  logic [14:0] ctl;

  int checks = 0;
  int failures = 0;

  int          m_step = 0;
  bit          m_halt = 1'b0;
  bit          m_cond = 1'b0;
  logic [14:0] prev_en = '0;

  control_sequencer #(.BUS_WIDTH(16)) dut (
    .CLOCK(clock), .RESET(reset), .RUN(run), .INSTRUCTION(instruction),
    .FLAG_C(flag_c), .FLAG_Z(flag_z),
    .PC_ENABLE(pc_enable), .PC_COUNT(pc_count), .PC_LOAD(pc_load), .MAR_LOAD(mar_load),
    .RAM_ENABLE(ram_enable), .RAM_LOAD(ram_load), .IR_LOAD(ir_load), .IR_ENABLE(ir_enable),
    .A_ENABLE(a_enable), .A_LOAD(a_load), .B_LOAD(b_load), .ALU_ENABLE(alu_enable),
    .ALU_SUB(alu_sub), .FLAGS_LOAD(flags_load), .OUT_LOAD(out_load),
    .STEP(step), .HALTED(halted)
  );

  assign ctl = {pc_enable, pc_count, pc_load, mar_load, ram_enable, ram_load, ir_load,
                ir_enable, a_enable, a_load, b_load, alu_enable, alu_sub, flags_load, out_load};

  always #5 clock = ~clock;

  // Reference: each opcode's full microprogram as a list of control words.
  function automatic logic [14:0] prog(input logic [3:0] op, input bit c, input int idx,
                                       output int len);
    logic [14:0] p[$];
    p.push_back(K_PC_EN);
    p.push_back(K_MAR_LD);
    p.push_back(K_RAM_EN);
    p.push_back(K_IR_LD | K_PC_CNT);
    case (op)
      4'h1: begin p.push_back(K_IR_EN); p.push_back(K_MAR_LD); p.push_back(K_RAM_EN);
                  p.push_back(K_A_LD); end
      4'h2, 4'h3: begin
        p.push_back(K_IR_EN); p.push_back(K_MAR_LD); p.push_back(K_RAM_EN); p.push_back(K_B_LD);
        p.push_back(K_ALU_EN | ((op == 4'h3) ? K_ALU_SUB : 15'h0));
        p.push_back(K_A_LD | K_FLAGS_LD | ((op == 4'h3) ? K_ALU_SUB : 15'h0));
      end
      4'h4: begin p.push_back(K_IR_EN); p.push_back(K_MAR_LD | K_A_EN); p.push_back(K_RAM_LD); end
      4'h5: begin p.push_back(K_IR_EN); p.push_back(K_A_LD); end
      4'h6: begin p.push_back(K_IR_EN); p.push_back(K_PC_LD); end
      4'h7, 4'h8: begin p.push_back(K_IR_EN); p.push_back(c ? K_PC_LD : 15'h0); end
      4'hE: begin p.push_back(K_A_EN); p.push_back(K_OUT_LD); end
      4'hF: p.push_back(15'h0);
      default: ;
    endcase
    len = p.size();
    return (idx < len) ? p[idx] : 15'h0;
  endfunction

  always @(posedge clock) begin
    int len;
    logic [14:0] word;
    if (!reset) begin
      m_step = 0;
      m_halt = 1'b0;
      m_cond = 1'b0;
    end else if (run && !m_halt) begin
      if (m_step == 4) m_cond = (instruction[15:12] == 4'h8) ? flag_z : flag_c;
      word = prog(instruction[15:12], m_cond, m_step, len);
      if (m_step == len - 1) begin
        if (instruction[15:12] == 4'hF) m_halt = 1'b1;
        m_step = 0;
      end else begin
        m_step = m_step + 1;
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        run;
    logic [15:0] instr;
    logic [3:0]  exp_step;
    logic [14:0] exp_ctl;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[16];

  task automatic apply_stimulus(input logic r, input logic ru, input logic [15:0] ins,
                                input logic fc, input logic fz);
    reset = r;
    run = ru;
    instruction = ins;
    flag_c = fc;
    flag_z = fz;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h step=%0d", name, actual, expected, step);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_cycle(input string name, input bit props);
    int len;
    logic [14:0] exp;
    #1;
    exp = (!reset || !run || m_halt) ? 15'h0 : prog(instruction[15:12], m_cond, m_step, len);
    check_output(name, {halted, step, ctl}, {m_halt, 4'(m_step), exp});
    if (props) begin
      check_output("one_enable", 32'($countones(ctl & EN_MASK) <= 1), 32'd1);
      if ((ctl & LD_MASK) != 15'h0) check_output("load_after_enable", 32'(prev_en != 15'h0), 32'd1);
    end
    if (!reset) prev_en = 15'h0;
    else if (run && !m_halt) prev_en = ctl & EN_MASK;
    tick();
  endtask

  task automatic do_reset(input logic [15:0] ins);
    apply_stimulus(1'b0, 1'b1, ins, 1'b0, 1'b0);
    check_cycle("reset_cycle", 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    logic [14:0] fetch [4];
    int active;
    bit done;
    logic [3:0] rop;
    fetch[0] = K_PC_EN;
    fetch[1] = K_MAR_LD;
    fetch[2] = K_RAM_EN;
    fetch[3] = K_IR_LD | K_PC_CNT;

    vecs[0]  = '{1'b1, 1'b1, 16'h2005, 4'd0, K_PC_EN, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 16'h2005, 4'd1, K_MAR_LD, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'h2005, 4'd2, K_RAM_EN, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 16'h2005, 4'd3, K_IR_LD | K_PC_CNT, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 16'h2005, 4'd4, K_IR_EN, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 16'h2005, 4'd5, K_MAR_LD, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'h2005, 4'd6, K_RAM_EN, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 16'h2005, 4'd7, K_B_LD, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 16'h2005, 4'd8, K_ALU_EN, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 16'h2005, 4'd9, K_A_LD | K_FLAGS_LD, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 16'h2005, 4'd0, K_PC_EN, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h2005, 4'd1, 15'h0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 16'h2005, 4'd1, K_MAR_LD, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'h2005, 4'd2, 15'h0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 16'h2005, 4'd0, K_PC_EN, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 16'h2005, 4'd1, K_MAR_LD, 1'b0};

    apply_stimulus(1'b0, 1'b1, 16'h2005, 1'b0, 1'b0);
    tick();
    #1;
    check_output("reset_state", {halted, step, ctl}, {1'b0, 4'd0, 15'h0});
    @(negedge clock);

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].run, vecs[i].instr, 1'b1, 1'b1);
      #1;
      check_output($sformatf("vec%0d", i), {halted, step, ctl},
                   {vecs[i].exp_halted, vecs[i].exp_step, vecs[i].exp_ctl});
      tick();
    end

    // Conditional jump: only the flag seen on the T4 edge matters.
    do_reset(16'h7123);
    repeat (4) check_cycle("jc_fetch", 1'b0);
    flag_c = 1'b1;
    check_cycle("jc_t4", 1'b0);
    flag_c = 1'b0;
    #1 check_output("jc_taken", {step, pc_load}, {4'd5, 1'b1});
    check_cycle("jc_t5", 1'b0);
    repeat (4) check_cycle("jc2_fetch", 1'b0);
    flag_c = 1'b0;
    check_cycle("jc2_t4", 1'b0);
    flag_c = 1'b1;
    #1 check_output("jc_not_taken", {step, ctl}, {4'd5, 15'h0});
    check_cycle("jc2_t5", 1'b0);
    #1 check_output("jc_wrap", step, 4'd0);

    do_reset(16'hF000);
    repeat (5) check_cycle("hlt_run", 1'b0);
    for (int i = 0; i < 20; i++) begin
      flag_c = 1'($urandom);
      #1 check_output("halt_idle", {halted, step, ctl}, {1'b1, 4'd0, 15'h0});
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1 check_output("halt_exit", {halted, step, ctl}, {1'b0, 4'd0, K_PC_EN});
    @(negedge clock);

    // LDA with a three-cycle RUN freeze at T5.
    do_reset(16'h100A);
    active = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      run = !(cyc >= 5 && cyc < 8);
      #1;
      if (run) active++;
      if (!run) check_output("lda_frozen", {step, ctl}, {4'd5, 15'h0});
      if (run && step == 4'd5) check_output("lda_mar", ctl, K_MAR_LD);
      if (run && step == 4'd7) check_output("lda_aload", ctl, K_A_LD);
      tick();
      done = (step == 4'd0);
    end
    check_output("lda_active_cycles", active, 8);

    do_reset(16'h3004);
    repeat (8) check_cycle("sub_run", 1'b0);
    #1 check_output("sub_t8", {step, ctl}, {4'd8, K_ALU_EN | K_ALU_SUB});
    reset = 1'b0;
    #1 check_output("sub_reset_quiet", ctl, 15'h0);
    tick();
    apply_stimulus(1'b1, 1'b1, 16'hA000, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1 check_output("undef_loop", {step, ctl}, {4'(cyc % 4), fetch[cyc % 4]});
      tick();
    end

    // Random instruction stream with random RUN, flags and occasional reset.
    do_reset(16'h0000);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = !((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0);
      run = ($urandom_range(0, 9) != 0);
      flag_c = 1'($urandom);
      flag_z = 1'($urandom);
      if (m_step == 0 && !m_halt) begin
        rop = 4'($urandom_range(0, 15));
        instruction = {rop, 12'($urandom)};
      end
      check_cycle("random", 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
